// File: rtl/sdram_init_monitor_pkg.sv
// ----------------------------------------------------------------------------
// sdram_init_monitor_pkg
//
// Shared definitions for the SDRAM power-up command stream monitor:
//   - raw {CS#, RAS#, CAS#, WE#} encodings of the commands the monitor cares about
//   - the decoded command kind and the monitor state enumerations
//   - the sticky error codes reported on dev_err_code
//   - mode register field positions and the reserved-bit check for MRS
// ----------------------------------------------------------------------------
package sdram_init_monitor_pkg;

    localparam logic [3:0] CMD_MRS = 4'b0000;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        K_NOP,
        K_PRE,
        K_AR,
        K_MRS,
        K_OTHER
    } cmd_kind_e;

    typedef enum logic [2:0] {
        S_PWR,
        S_WPRE,
        S_TRP,
        S_TRFC,
        S_TMRD,
        S_READY,
        S_ERR
    } state_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_EARLY   = 3'd1;
    localparam logic [2:0] ERR_SEQ     = 3'd2;
    localparam logic [2:0] ERR_TRP     = 3'd3;
    localparam logic [2:0] ERR_TRFC    = 3'd4;
    localparam logic [2:0] ERR_TMRD    = 3'd5;
    localparam logic [2:0] ERR_PRE_A10 = 3'd6;
    localparam logic [2:0] ERR_MRS_RSV = 3'd7;

    // Mode register layout: burst length A2..A0, burst type A3,
    // CAS latency A6..A4, write burst mode A9. Every other bit is reserved.
    localparam int A10_BIT = 10;
    localparam int BL_LSB  = 0;
    localparam int BT_BIT  = 3;
    localparam int CL_LSB  = 4;
    localparam int CL_MSB  = 6;
    localparam int WB_BIT  = 9;

    localparam logic [2:0] CL_2 = 3'b010;
    localparam logic [2:0] CL_3 = 3'b011;

    localparam logic [12:0] MRS_DEF_MASK = (13'b111 << BL_LSB) | (13'b1 << BT_BIT) |
                                           (13'b111 << CL_LSB) | (13'b1 << WB_BIT);

    // Deselect (CS# high) and the explicit NOP encoding are both idle cycles;
    // anything outside the three init commands is lumped into K_OTHER.
    function automatic cmd_kind_e decode_cmd(input logic [3:0] cmd);
        cmd_kind_e kind;
        if (cmd[3] || cmd == CMD_NOP) begin
            kind = K_NOP;
        end else if (cmd == CMD_PRE) begin
            kind = K_PRE;
        end else if (cmd == CMD_AR) begin
            kind = K_AR;
        end else if (cmd == CMD_MRS) begin
            kind = K_MRS;
        end else begin
            kind = K_OTHER;
        end
        return kind;
    endfunction

    // An MRS is malformed if any reserved address bit is set, the CAS latency
    // is not 2 or 3, or it targets anything but the base mode register (BA=00).
    function automatic logic mrs_fields_bad(input logic [12:0] addr, input logic [1:0] bank);
        logic [2:0] cl;
        cl = addr[CL_MSB:CL_LSB];
        return (bank != 2'b00) || ((addr & ~MRS_DEF_MASK) != 13'd0) ||
               ((cl != CL_2) && (cl != CL_3));
    endfunction

endpackage

// File: rtl/sdram_init_monitor.sv
// ----------------------------------------------------------------------------
// sdram_init_monitor
//
// Device-side checker for the SDRAM power-up command stream. It decodes the
// command bus every clock and checks the init order (power-up wait,
// PRECHARGE-ALL, at least AR_MIN auto refreshes, MODE REGISTER SET) plus the
// tRP / tRFC / tMRD spacing in clock cycles.
//
// Ports:
//   dev_clk       clock
//   dev_rst_n     synchronous active-low reset
//   dev_cmd       {CS#, RAS#, CAS#, WE#}
//   dev_bank      bank address (only checked on MRS)
//   dev_addr      address bus A12..A0
//   dev_ready     init sequence completed legally
//   dev_mode      mode register value captured from the accepted MRS
//   dev_ar_cnt    accepted auto refreshes, saturating at 15
//   dev_err       sticky error flag
//   dev_err_code  code of the first error detected
// ----------------------------------------------------------------------------
module sdram_init_monitor
    import sdram_init_monitor_pkg::*;
#(
    parameter int PWR_CYC  = 20000,
    parameter int TRP_CYC  = 2,
    parameter int TRFC_CYC = 7,
    parameter int TMRD_CYC = 2,
    parameter int AR_MIN   = 2
) (
    input  logic        dev_clk,
    input  logic        dev_rst_n,
    input  logic [3:0]  dev_cmd,
    input  logic [1:0]  dev_bank,
    input  logic [12:0] dev_addr,
    output logic        dev_ready,
    output logic [12:0] dev_mode,
    output logic [3:0]  dev_ar_cnt,
    output logic        dev_err,
    output logic [2:0]  dev_err_code
);

    localparam logic [15:0] PWR_LIM  = 16'(PWR_CYC);
    localparam logic [3:0]  TRP_GAP  = 4'(TRP_CYC);
    localparam logic [3:0]  TRFC_GAP = 4'(TRFC_CYC);
    localparam logic [3:0]  TMRD_GAP = 4'(TMRD_CYC);
    localparam logic [3:0]  AR_LIM   = 4'(AR_MIN);

    state_e      state;
    logic [15:0] pwr_cnt;
    logic [3:0]  gap_cnt;
    cmd_kind_e   kind;
    logic        fields_bad;
    logic        a10;
    logic [2:0]  chk_err;

    assign kind       = decode_cmd(dev_cmd);
    assign fields_bad = (kind == K_MRS) && mrs_fields_bad(dev_addr, dev_bank);
    assign a10        = dev_addr[A10_BIT];

    // Free-running bookkeeping. The power counter measures time since reset
    // release and parks at PWR_CYC. The gap counter reads N in the cycle N
    // clocks after the most recent non-NOP command, so a command is legal when
    // the gap has reached the relevant minimum spacing.
    always_ff @(posedge dev_clk) begin
        if (!dev_rst_n) begin
            pwr_cnt <= 16'd0;
            gap_cnt <= 4'd0;
        end else begin
            if (pwr_cnt < PWR_LIM) begin
                pwr_cnt <= pwr_cnt + 16'd1;
            end
            if (kind != K_NOP) begin
                gap_cnt <= 4'd1;
            end else if (gap_cnt != 4'd15) begin
                gap_cnt <= gap_cnt + 4'd1;
            end
        end
    end

    // Classify the current command against the current state and produce the
    // error it would cause (ERR_NONE if it is acceptable). The if-chains encode
    // the priority: early command first, then a malformed MRS, then spacing
    // violations, then a PRECHARGE without A10, and finally plain ordering.
    always_comb begin
        chk_err = ERR_NONE;
        if (kind != K_NOP) begin
            case (state)
                S_PWR, S_WPRE: begin
                    if (state == S_PWR && pwr_cnt < PWR_LIM) begin
                        chk_err = ERR_EARLY;
                    end else if (fields_bad) begin
                        chk_err = ERR_MRS_RSV;
                    end else if (kind == K_PRE && !a10) begin
                        chk_err = ERR_PRE_A10;
                    end else if (kind != K_PRE) begin
                        chk_err = ERR_SEQ;
                    end
                end
                S_TRP: begin
                    if (fields_bad) begin
                        chk_err = ERR_MRS_RSV;
                    end else if (gap_cnt < TRP_GAP) begin
                        chk_err = ERR_TRP;
                    end else if (kind == K_PRE && !a10) begin
                        chk_err = ERR_PRE_A10;
                    end else if (kind != K_PRE && kind != K_AR) begin
                        chk_err = ERR_SEQ;
                    end
                end
                S_TRFC: begin
                    if (fields_bad) begin
                        chk_err = ERR_MRS_RSV;
                    end else if (gap_cnt < TRFC_GAP) begin
                        chk_err = ERR_TRFC;
                    end else if (kind == K_PRE && !a10) begin
                        chk_err = ERR_PRE_A10;
                    end else if ((kind == K_MRS && dev_ar_cnt < AR_LIM) ||
                                 kind == K_PRE || kind == K_OTHER) begin
                        chk_err = ERR_SEQ;
                    end
                end
                S_TMRD: begin
                    if (gap_cnt < TMRD_GAP) begin
                        chk_err = ERR_TMRD;
                    end
                end
                default: begin
                    chk_err = ERR_NONE;
                end
            endcase
        end
    end

    // Init sequence FSM with registered outputs. Any error moves to S_ERR and
    // freezes the first code; S_READY and S_ERR are terminal until reset. In
    // S_PWR a PRECHARGE that clears every check is taken directly, which is the
    // same as passing through S_WPRE in the same cycle.
    always_ff @(posedge dev_clk) begin
        if (!dev_rst_n) begin
            state        <= S_PWR;
            dev_ready    <= 1'b0;
            dev_mode     <= 13'd0;
            dev_ar_cnt   <= 4'd0;
            dev_err      <= 1'b0;
            dev_err_code <= ERR_NONE;
        end else begin
            case (state)
                S_READY, S_ERR: begin
                    state <= state;
                end
                default: begin
                    if (chk_err != ERR_NONE) begin
                        state        <= S_ERR;
                        dev_err      <= 1'b1;
                        dev_err_code <= chk_err;
                        dev_ready    <= 1'b0;
                    end else begin
                        case (state)
                            S_PWR: begin
                                if (kind == K_PRE) begin
                                    state <= S_TRP;
                                end else if (pwr_cnt >= PWR_LIM) begin
                                    state <= S_WPRE;
                                end
                            end
                            S_WPRE: begin
                                if (kind == K_PRE) begin
                                    state <= S_TRP;
                                end
                            end
                            S_TRP: begin
                                if (kind == K_AR) begin
                                    state <= S_TRFC;
                                    if (dev_ar_cnt != 4'd15) begin
                                        dev_ar_cnt <= dev_ar_cnt + 4'd1;
                                    end
                                end
                            end
                            S_TRFC: begin
                                if (kind == K_AR) begin
                                    if (dev_ar_cnt != 4'd15) begin
                                        dev_ar_cnt <= dev_ar_cnt + 4'd1;
                                    end
                                end else if (kind == K_MRS) begin
                                    state    <= S_TMRD;
                                    dev_mode <= dev_addr;
                                end
                            end
                            S_TMRD: begin
                                if (gap_cnt >= TMRD_GAP) begin
                                    state     <= S_READY;
                                    dev_ready <= 1'b1;
                                end
                            end
                            default: begin
                                state <= state;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init_monitor.sv
// ----------------------------------------------------------------------------
// tb_sdram_init_monitor
//
// Drives directed init streams (legal, early, spacing, ordering and field
// violations, mid-sequence reset) followed by randomized streams, and compares
// every cycle against a reference model that describes the init rules as a
// grammar over the accepted command history.
// ----------------------------------------------------------------------------
module tb_sdram_init_monitor;

    localparam int PWR   = 20;
    localparam int TRP   = 2;
    localparam int TRFC  = 7;
    localparam int TMRD  = 2;
    localparam int ARMIN = 2;

    // Command kinds used by the model: 0 idle, 1 PRE, 2 AR, 3 MRS, 4 other.
    localparam int KN = 0;
    localparam int KP = 1;
    localparam int KA = 2;
    localparam int KM = 3;
    localparam int KO = 4;

    logic        dev_clk = 1'b0;
    logic        dev_rst_n;
    logic [3:0]  dev_cmd;
    logic [1:0]  dev_bank;
    logic [12:0] dev_addr;
    logic        dev_ready;
    logic [12:0] dev_mode;
    logic [3:0]  dev_ar_cnt;
    logic        dev_err;
    logic [2:0]  dev_err_code;

    int total = 0;
    int bad   = 0;
    string scen = "init";

    int          m_t;
    int          m_last_kind;
    int          m_last_t;
    int          m_ar;
    logic [12:0] m_mode;
    bit          m_ready;
    bit          m_err;
    int          m_code;

    always #5 dev_clk = ~dev_clk;

    sdram_init_monitor #(
        .PWR_CYC  (PWR),
        .TRP_CYC  (TRP),
        .TRFC_CYC (TRFC),
        .TMRD_CYC (TMRD),
        .AR_MIN   (ARMIN)
    ) dut (
        .dev_clk      (dev_clk),
        .dev_rst_n    (dev_rst_n),
        .dev_cmd      (dev_cmd),
        .dev_bank     (dev_bank),
        .dev_addr     (dev_addr),
        .dev_ready    (dev_ready),
        .dev_mode     (dev_mode),
        .dev_ar_cnt   (dev_ar_cnt),
        .dev_err      (dev_err),
        .dev_err_code (dev_err_code)
    );

    function automatic int classify(input logic [3:0] c);
        if (c[3] == 1'b1 || c == 4'b0111) return KN;
        if (c == 4'b0010) return KP;
        if (c == 4'b0001) return KA;
        if (c == 4'b0000) return KM;
        return KO;
    endfunction

    function automatic bit modeBad(input logic [1:0] ba, input logic [12:0] a);
        return (ba != 2'b00) || (a[12:10] != 3'b000) || (a[8:7] != 2'b00) ||
               !(a[6:4] == 3'd2 || a[6:4] == 3'd3);
    endfunction

    function automatic int needGap(input int k);
        if (k == KP) return TRP;
        if (k == KA) return TRFC;
        if (k == KM) return TMRD;
        return 0;
    endfunction

    function automatic int timingCode(input int k);
        if (k == KP) return 3;
        if (k == KA) return 4;
        return 5;
    endfunction

    function automatic bit allowedAfter(input int last, input int k, input int ar);
        if (last == KN) return (k == KP);
        if (last == KP) return (k == KP || k == KA);
        if (last == KA) return (k == KA || (k == KM && ar >= ARMIN));
        return 1'b0;
    endfunction

    // Reference model: the init stream is a grammar PRE+ AR{AR_MIN,} MRS with
    // minimum distances between successive accepted commands, measured as
    // absolute cycle numbers since reset release.
    task automatic modelStep(input logic rst, input logic [3:0] cmd,
                             input logic [1:0] ba, input logic [12:0] addr);
        int k;
        int code;
        if (!rst) begin
            m_t = 0; m_last_kind = KN; m_last_t = 0; m_ar = 0;
            m_mode = 13'd0; m_ready = 0; m_err = 0; m_code = 0;
            return;
        end
        k = classify(cmd);
        code = 0;
        if (!m_err && !m_ready) begin
            if (m_last_kind == KM) begin
                if (m_t - m_last_t >= TMRD) m_ready = 1;
                else if (k != KN) code = 5;
            end else if (k != KN) begin
                if (m_t < PWR) code = 1;
                else if (k == KM && modeBad(ba, addr)) code = 7;
                else if (m_last_kind != KN && (m_t - m_last_t) < needGap(m_last_kind))
                    code = timingCode(m_last_kind);
                else if (k == KP && addr[10] == 1'b0) code = 6;
                else if (!allowedAfter(m_last_kind, k, m_ar)) code = 2;
                if (code == 0) begin
                    m_last_kind = k;
                    m_last_t    = m_t;
                    if (k == KA && m_ar < 15) m_ar++;
                    if (k == KM) m_mode = addr;
                end
            end
            if (code != 0) begin
                m_err  = 1;
                m_code = code;
            end
        end
        m_t++;
    endtask

    // Compare every DUT output with the model after each clock edge.
    task automatic checkOutput();
        total++;
        assert (dev_ready === m_ready) else begin
            bad++; $error("[TB] FAIL %s.ready got=%0b exp=%0b", scen, dev_ready, m_ready);
        end
        total++;
        assert (dev_mode === m_mode) else begin
            bad++; $error("[TB] FAIL %s.mode got=%0h exp=%0h", scen, dev_mode, m_mode);
        end
        total++;
        assert (dev_ar_cnt === 4'(m_ar)) else begin
            bad++; $error("[TB] FAIL %s.ar_cnt got=%0d exp=%0d", scen, dev_ar_cnt, m_ar);
        end
        total++;
        assert (dev_err === m_err) else begin
            bad++; $error("[TB] FAIL %s.err got=%0b exp=%0b", scen, dev_err, m_err);
        end
        total++;
        assert (dev_err_code === 3'(m_code)) else begin
            bad++; $error("[TB] FAIL %s.err_code got=%0d exp=%0d", scen, dev_err_code, m_code);
        end
    endtask

    // Independent hand-derived expectations at key points of directed scenarios.
    task automatic directCheck(input string tag, input int got, input int expv);
        total++;
        assert (got == expv) else begin
            bad++; $error("[TB] FAIL %s.%s got=%0d exp=%0d", scen, tag, got, expv);
        end
    endtask

    // One clock cycle: drive inputs, take the edge, step the model, compare.
    task automatic applyStimulus(input logic rst, input logic [3:0] cmd,
                                 input logic [1:0] ba, input logic [12:0] addr);
        dev_rst_n = rst;
        dev_cmd   = cmd;
        dev_bank  = ba;
        dev_addr  = addr;
        @(posedge dev_clk);
        #1;
        modelStep(rst, cmd, ba, addr);
        checkOutput();
    endtask

    function automatic logic [3:0] randNop();
        if ($urandom_range(0, 3) == 0) return 4'b0111;
        return {1'b1, 3'($urandom)};
    endfunction

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, randNop(), 2'($urandom), 13'($urandom));
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'b0111, 2'b00, 13'd0);
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr);
        applyStimulus(1'b1, cmd, ba, addr);
    endtask

    // PRE-all, AR, AR, MRS with minimum legal spacing, then idle cycles.
    task automatic legalBody(input logic [12:0] mode);
        issue(4'b0010, 2'b00, 13'h0400);
        nops(TRP - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(TRFC - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(TRFC - 1);
        issue(4'b0000, 2'b00, mode);
        nops(4);
    endtask

    task automatic upToMrs();
        doReset(2);
        nops(PWR + 1);
        issue(4'b0010, 2'b00, 13'h0400);
        nops(TRP - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(TRFC - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(TRFC - 1);
    endtask

    initial begin
        logic [12:0] a;
        logic [1:0]  ba;
        int          g;
        int          nref;
        bit          corrupt;

        dev_rst_n = 1'b0;
        dev_cmd   = 4'b0111;
        dev_bank  = 2'b00;
        dev_addr  = 13'd0;

        scen = "reset";
        doReset(2);
        directCheck("rst_ready", int'(dev_ready), 0);
        directCheck("rst_code", int'(dev_err_code), 0);

        scen = "legal";
        doReset(2);
        nops(PWR + 1);
        legalBody(13'h037);
        directCheck("ready", int'(dev_ready), 1);
        directCheck("mode", int'(dev_mode), 'h037);
        directCheck("ar_cnt", int'(dev_ar_cnt), 2);
        directCheck("err", int'(dev_err), 0);

        scen = "early";
        doReset(2);
        nops(10);
        issue(4'b0010, 2'b00, 13'h0400);
        directCheck("code", int'(dev_err_code), 1);
        nops(15);
        legalBody(13'h037);
        directCheck("ready", int'(dev_ready), 0);
        directCheck("code_held", int'(dev_err_code), 1);

        scen = "trp";
        doReset(2);
        nops(PWR + 1);
        issue(4'b0010, 2'b00, 13'h0400);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(2);
        directCheck("code", int'(dev_err_code), 3);

        scen = "trfc";
        doReset(2);
        nops(PWR + 1);
        issue(4'b0010, 2'b00, 13'h0400);
        nops(TRP - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(4);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(2);
        directCheck("code", int'(dev_err_code), 4);

        scen = "one_ar";
        doReset(2);
        nops(PWR + 1);
        issue(4'b0010, 2'b00, 13'h0400);
        nops(TRP - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(TRFC - 1);
        issue(4'b0000, 2'b00, 13'h037);
        nops(2);
        directCheck("code", int'(dev_err_code), 2);

        scen = "pre_a10";
        doReset(2);
        nops(PWR + 1);
        issue(4'b0010, 2'b00, 13'h0000);
        nops(2);
        directCheck("code", int'(dev_err_code), 6);

        scen = "mrs_a10";
        upToMrs();
        issue(4'b0000, 2'b00, 13'h0437);
        nops(2);
        directCheck("code", int'(dev_err_code), 7);

        scen = "mrs_cl1";
        upToMrs();
        issue(4'b0000, 2'b00, 13'h017);
        nops(2);
        directCheck("code", int'(dev_err_code), 7);

        scen = "mrs_ba";
        upToMrs();
        issue(4'b0000, 2'b01, 13'h037);
        nops(2);
        directCheck("code", int'(dev_err_code), 7);

        scen = "tmrd";
        upToMrs();
        issue(4'b0000, 2'b00, 13'h037);
        issue(4'b0001, 2'b00, 13'h000);
        nops(2);
        directCheck("code", int'(dev_err_code), 5);

        scen = "mid_reset";
        doReset(2);
        nops(PWR + 1);
        issue(4'b0010, 2'b00, 13'h0400);
        nops(TRP - 1);
        issue(4'b0001, 2'b00, 13'h0000);
        nops(3);
        doReset(1);
        directCheck("ar_cnt", int'(dev_ar_cnt), 0);
        directCheck("ready", int'(dev_ready), 0);
        nops(PWR + 1);
        legalBody(13'h037);
        directCheck("ready", int'(dev_ready), 1);
        directCheck("ar_cnt", int'(dev_ar_cnt), 2);

        scen = "random";
        for (int it = 0; it < 30; it++) begin
            doReset(1);
            nops($urandom_range(PWR - 2, PWR + 3));
            a = 13'($urandom);
            a[10] = ($urandom_range(0, 9) != 0);
            issue(4'b0010, 2'($urandom), a);
            nref = $urandom_range(1, 4);
            for (int r = 0; r < nref; r++) begin
                g = (r == 0) ? TRP : TRFC;
                if ($urandom_range(0, 7) != 0) g = $urandom_range(g, g + 3);
                else g = g - 1;
                nops(g - 1);
                issue(4'b0001, 2'($urandom), 13'($urandom));
            end
            nops($urandom_range(TRFC - 1, TRFC + 2));
            if ($urandom_range(0, 9) == 0) begin
                issue(4'($urandom_range(3, 6)), 2'b00, 13'($urandom));
            end
            a = 13'($urandom) & 13'h027F;
            a[6:4] = 3'($urandom_range(2, 3));
            ba = 2'b00;
            corrupt = ($urandom_range(0, 5) == 0);
            if (corrupt) begin
                case ($urandom_range(0, 3))
                    0: a[$urandom_range(10, 12)] = 1'b1;
                    1: a[$urandom_range(7, 8)] = 1'b1;
                    2: a[6:4] = 3'($urandom_range(4, 7));
                    default: ba = 2'($urandom_range(1, 3));
                endcase
            end
            issue(4'b0000, ba, a);
            if ($urandom_range(0, 4) == 0) begin
                issue(4'b0001, 2'b00, 13'd0);
            end
            nops(4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
